// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths and the "no producer" tag for the Tomasulo datapath blocks.
package tomasulo_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int TAG_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam logic [4:0] INVALID_TAG_DEF = 5'b11111;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, searching upward from ptr modulo N.
module rr_picker #(
  parameter int N = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [PW-1:0] idx;
  // Walk from farthest to nearest so the closest requester at or after ptr wins.
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit one-entry holding buffers arbitrated round-robin onto the common data bus.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [TAG_W-1:0] INVALID_TAG = TAG_W'(INVALID_TAG_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        in_req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  in_req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] in_req_val,
  output logic [NUM_REQ-1:0]        out_req_ready,
  input  logic                      in_flush,
  output logic                      out_CDB_broadcast,
  output logic [TAG_W-1:0]          out_CDB_tag,
  output logic [DATA_W-1:0]         out_CDB_val,
  output logic                      out_busy
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d, grant, keep;
  logic [TAG_W-1:0]   buf_tag_q [NUM_REQ];
  logic [DATA_W-1:0]  buf_val_q [NUM_REQ];
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d, g;
  logic [TAG_W-1:0]   sel_tag;
  logic [DATA_W-1:0]  sel_val;
  logic               bcast_q;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W-1:0]  val_q;
  rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (buf_valid_q & {NUM_REQ{!rst && !in_flush}}),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );
  // A granted buffer frees itself this cycle, so it can take a refill at the same edge.
  assign out_req_ready = (~buf_valid_q | grant) & {NUM_REQ{!rst && !in_flush}};
  always_comb begin
    sel_tag = INVALID_TAG;
    sel_val = '0;
    g = '0;
    keep = '0;
    buf_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_tag = buf_tag_q[i];
        sel_val = buf_val_q[i];
        g = PW'(i);
      end
      keep[i] = in_req_valid[i] && out_req_ready[i] && in_req_tag[i*TAG_W +: TAG_W] != INVALID_TAG;
      buf_valid_d[i] = in_flush ? 1'b0 : keep[i] ? 1'b1 : grant[i] ? 1'b0 : buf_valid_q[i];
    end
    rr_ptr_d = !(|grant) ? rr_ptr_q : (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= '0;
      rr_ptr_q <= '0;
      bcast_q <= 1'b0;
      tag_q <= INVALID_TAG;
      val_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_ptr_q <= rr_ptr_d;
      bcast_q <= |grant;
      tag_q <= sel_tag;
      val_q <= sel_val;
      for (int i = 0; i < NUM_REQ; i++)
        if (keep[i]) begin
          buf_tag_q[i] <= in_req_tag[i*TAG_W +: TAG_W];
          buf_val_q[i] <= in_req_val[i*DATA_W +: DATA_W];
        end
    end
  end
  assign out_CDB_broadcast = bcast_q;
  assign out_CDB_tag = tag_q;
  assign out_CDB_val = val_q;
  assign out_busy = |buf_valid_q;
endmodule
